// File: rtl/word_packer_if.sv
// Handshake bundle for word_packer: narrow beat input side, wide word output side
// and the flush request. slave = the packer, master = whatever drives it.
interface word_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
) ();
  logic                  valid_data_in;
  logic [IN_W-1:0]       data_in;
  logic                  ready_out;
  logic                  flush_in;
  logic                  valid_data_out;
  logic [IN_W*RATIO-1:0] data_out;
  logic [RATIO-1:0]      keep_out;
  logic                  ready_in;

  // Valid/ready: a transfer happens on a rising edge where both are high;
  // valid holds its payload stable until it is taken, ready may change freely.
  modport slave (
    input  valid_data_in, data_in, flush_in, ready_in,
    output ready_out, valid_data_out, data_out, keep_out
  );

  modport master (
    output valid_data_in, data_in, flush_in, ready_in,
    input  ready_out, valid_data_out, data_out, keep_out
  );
endinterface

// File: rtl/word_packer.sv
// Packs RATIO narrow beats into one wide word with selectable lane order,
// ready/valid on both sides and a flush that emits partial words with a keep mask.
module word_packer #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  word_packer_if.slave bus
);
  localparam int W  = IN_W * RATIO;
  localparam int CW = $clog2(RATIO);

  logic [W-1:0]     acc_q, acc_d;
  logic [RATIO-1:0] lane_keep_q, lane_keep_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;

  logic             ready;
  logic             accept;
  logic             last_beat;
  logic             flush_req;
  logic             emit;
  int               lane;
  logic [W-1:0]     acc_n;
  logic [RATIO-1:0] keep_n;

  assign ready              = !out_valid_q || bus.ready_in;
  assign bus.ready_out      = ready;
  assign bus.valid_data_out = out_valid_q;
  assign bus.data_out       = out_data_q;
  assign bus.keep_out       = out_keep_q;

  always_comb begin
    accept    = bus.valid_data_in && ready;
    lane      = (LSB_FIRST != 0) ? int'(cnt_q) : (RATIO - 1 - int'(cnt_q));
    acc_n     = acc_q;
    keep_n    = lane_keep_q;
    for (int i = 0; i < RATIO; i++) begin
      if (accept && (i == lane)) begin
        acc_n[i*IN_W +: IN_W] = bus.data_in;
        keep_n[i]             = 1'b1;
      end
    end
    last_beat = accept && (cnt_q == CW'(RATIO - 1));
    flush_req = bus.flush_in || flush_pend_q;
    // The beat of this cycle is packed before a flush is considered, so a
    // flush alongside a beat always carries that beat out.
    emit      = last_beat || (flush_req && ready && (keep_n != '0));
  end

  always_comb begin
    acc_d        = acc_n;
    lane_keep_d  = keep_n;
    cnt_d        = accept ? cnt_q + CW'(1) : cnt_q;
    flush_pend_d = flush_req && !ready;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    if (out_valid_q && bus.ready_in) begin
      out_valid_d = 1'b0;
    end
    if (emit) begin
      // Lanes are cleared per word, so unfilled lanes of a partial are already 0.
      out_valid_d = 1'b1;
      out_data_d  = acc_n;
      out_keep_d  = keep_n;
      acc_d       = '0;
      lane_keep_d = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q        <= '0;
      lane_keep_q  <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      lane_keep_q  <= lane_keep_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
    end
  end
endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: three configurations (default, MSB-first, 4-bit x 3)
// with hand-computed expected words queued and checked by per-DUT monitors.
module tb_word_packer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  word_packer_if #(.IN_W(8), .RATIO(4)) a_if ();
  word_packer_if #(.IN_W(8), .RATIO(4)) b_if ();
  word_packer_if #(.IN_W(4), .RATIO(3)) c_if ();

  word_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(1)) dut_a (.clk_in(clk), .rst_in(rst), .bus(a_if));
  word_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(0)) dut_b (.clk_in(clk), .rst_in(rst), .bus(b_if));
  word_packer #(.IN_W(4), .RATIO(3), .LSB_FIRST(1)) dut_c (.clk_in(clk), .rst_in(rst), .bus(c_if));

  // expected entries are {keep, data}
  logic [35:0] a_exp_q[$];
  logic [35:0] b_exp_q[$];
  logic [14:0] c_exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  // Drivers: called at posedge+1, return at posedge+1 after the beat is taken.
  task automatic a_send(input logic [7:0] d, input logic fl);
    bit ok;
    ok = 0;
    a_if.valid_data_in = 1'b1; a_if.data_in = d; a_if.flush_in = fl;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (a_if.ready_out) ok = 1;
    end
    if (!ok) timeout_fail("a_send");
    @(posedge clk); #1;
    a_if.valid_data_in = 1'b0; a_if.flush_in = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d, input logic fl);
    bit ok;
    ok = 0;
    b_if.valid_data_in = 1'b1; b_if.data_in = d; b_if.flush_in = fl;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (b_if.ready_out) ok = 1;
    end
    if (!ok) timeout_fail("b_send");
    @(posedge clk); #1;
    b_if.valid_data_in = 1'b0; b_if.flush_in = 1'b0;
  endtask

  task automatic c_send(input logic [3:0] d, input logic fl);
    bit ok;
    ok = 0;
    c_if.valid_data_in = 1'b1; c_if.data_in = d; c_if.flush_in = fl;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (c_if.ready_out) ok = 1;
    end
    if (!ok) timeout_fail("c_send");
    @(posedge clk); #1;
    c_if.valid_data_in = 1'b0; c_if.flush_in = 1'b0;
  endtask

  task automatic a_flush();
    a_if.flush_in = 1'b1;
    @(posedge clk); #1;
    a_if.flush_in = 1'b0;
  endtask

  task automatic b_flush();
    b_if.flush_in = 1'b1;
    @(posedge clk); #1;
    b_if.flush_in = 1'b0;
  endtask

  task automatic c_flush();
    c_if.flush_in = 1'b1;
    @(posedge clk); #1;
    c_if.flush_in = 1'b0;
  endtask

  // Monitors: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!rst && a_if.valid_data_out && a_if.ready_in) begin
      if (a_exp_q.size() == 0) begin
        timeout_fail("a_unexpected_word");
      end else begin
        chk("a_word", {28'd0, a_if.keep_out, a_if.data_out}, {28'd0, a_exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_if.valid_data_out && b_if.ready_in) begin
      if (b_exp_q.size() == 0) begin
        timeout_fail("b_unexpected_word");
      end else begin
        chk("b_word", {28'd0, b_if.keep_out, b_if.data_out}, {28'd0, b_exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && c_if.valid_data_out && c_if.ready_in) begin
      if (c_exp_q.size() == 0) begin
        timeout_fail("c_unexpected_word");
      end else begin
        chk("c_word", {49'd0, c_if.keep_out, c_if.data_out}, {49'd0, c_exp_q.pop_front()});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_if.valid_data_in = 0; a_if.data_in = 0; a_if.flush_in = 0; a_if.ready_in = 1;
    b_if.valid_data_in = 0; b_if.data_in = 0; b_if.flush_in = 0; b_if.ready_in = 1;
    c_if.valid_data_in = 0; c_if.data_in = 0; c_if.flush_in = 0; c_if.ready_in = 1;
    #12;
    chk("reset_valid", {63'd0, a_if.valid_data_out}, 64'd0);
    chk("reset_data", {32'd0, a_if.data_out}, 64'd0);
    chk("reset_keep", {60'd0, a_if.keep_out}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_ready", {63'd0, a_if.ready_out}, 64'd1);

    // Full word, LSB first, with one-cycle valid
    a_exp_q.push_back({4'hF, 32'h44332211});
    a_send(8'h11, 0); a_send(8'h22, 0); a_send(8'h33, 0); a_send(8'h44, 0);
    @(negedge clk); chk("a_full_valid", {63'd0, a_if.valid_data_out}, 64'd1);
    @(negedge clk); chk("a_full_one_cycle", {63'd0, a_if.valid_data_out}, 64'd0);

    // Partial flush, then flush with an empty accumulator
    @(posedge clk); #1;
    a_exp_q.push_back({4'b0011, 32'h0000BBAA});
    a_send(8'hAA, 0); a_send(8'hBB, 0); a_flush();
    @(negedge clk);
    @(posedge clk); #1;
    a_flush();
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); chk("a_empty_flush_no_valid", {63'd0, a_if.valid_data_out}, 64'd0);
    end

    // Stream 12 beats with a downstream stall on the first word
    @(posedge clk); #1;
    a_exp_q.push_back({4'hF, 32'h04030201});
    a_exp_q.push_back({4'hF, 32'h08070605});
    a_exp_q.push_back({4'hF, 32'h0C0B0A09});
    a_if.ready_in = 1'b0;
    fork
      begin
        for (int i = 1; i <= 12; i++) a_send(8'(i), 0);
      end
      begin
        bit found;
        found = 0;
        for (int t = 0; t < 100 && !found; t++) begin
          @(negedge clk);
          if (a_if.valid_data_out) found = 1;
        end
        if (!found) timeout_fail("a_stall_wait");
        for (int s = 0; s < 3; s++) begin
          if (s > 0) @(negedge clk);
          chk("a_stall_ready_low", {63'd0, a_if.ready_out}, 64'd0);
          chk("a_stall_hold", {32'd0, a_if.data_out}, 64'h04030201);
        end
        @(posedge clk); #1;
        a_if.ready_in = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // Flush while stalled stays pending and carries the beat of the release cycle
    a_if.ready_in = 1'b0;
    a_exp_q.push_back({4'hF, 32'hC4C3C2C1});
    a_exp_q.push_back({4'b0001, 32'h0000005A});
    a_send(8'hC1, 0); a_send(8'hC2, 0); a_send(8'hC3, 0); a_send(8'hC4, 0);
    a_flush();
    a_if.ready_in = 1'b1;
    a_send(8'h5A, 0);
    repeat (4) @(posedge clk); #1;

    // Async reset while a word is held: outputs clear at once, word discarded
    a_if.ready_in = 1'b0;
    a_send(8'hD0, 0); a_send(8'hD1, 0); a_send(8'hD2, 0); a_send(8'hD3, 0);
    chk("a_held_before_reset", {63'd0, a_if.valid_data_out}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("a_async_rst_valid", {63'd0, a_if.valid_data_out}, 64'd0);
    chk("a_async_rst_data", {32'd0, a_if.data_out}, 64'd0);
    chk("a_async_rst_keep", {60'd0, a_if.keep_out}, 64'd0);
    @(negedge clk); rst = 1'b0; a_if.ready_in = 1'b1;
    @(posedge clk); #1;

    // Reset mid-word discards the partial
    a_send(8'hE1, 0); a_send(8'hE2, 0);
    #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    a_exp_q.push_back({4'hF, 32'h08070605});
    a_send(8'h05, 0); a_send(8'h06, 0); a_send(8'h07, 0); a_send(8'h08, 0);
    repeat (3) @(posedge clk); #1;

    // MSB-first lane order
    b_exp_q.push_back({4'hF, 32'h11223344});
    b_exp_q.push_back({4'b1100, 32'h11220000});
    b_send(8'h11, 0); b_send(8'h22, 0); b_send(8'h33, 0); b_send(8'h44, 0);
    b_send(8'h11, 0); b_send(8'h22, 0); b_flush();
    repeat (3) @(posedge clk); #1;

    // 4-bit x 3: flush on the final beat, flush alone, flush on a middle beat
    c_exp_q.push_back({3'b111, 12'h321});
    c_exp_q.push_back({3'b001, 12'h005});
    c_exp_q.push_back({3'b011, 12'h076});
    c_send(4'h1, 0); c_send(4'h2, 0); c_send(4'h3, 1);
    c_send(4'h5, 0); c_flush();
    c_send(4'h6, 0); c_send(4'h7, 1);
    repeat (10) @(posedge clk); #1;

    chk("a_queue_drained", 64'(a_exp_q.size()), 64'd0);
    chk("b_queue_drained", 64'(b_exp_q.size()), 64'd0);
    chk("c_queue_drained", 64'(c_exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Parametrised lane packer. Accumulates RATIO narrow IN_W-bit input beats into one IN_W*RATIO-bit output word.
- Adds three things the fixed 8-to-32 packer lacks: selectable lane order, a ready/valid backpressure handshake on both sides, and a flush that emits a partial word with a lane-keep mask.
- Sits between byte-stream sources (UART/SPI receivers, decoders) and word-wide consumers (BRAM writers, wide FIFOs).

Parameters:
- IN_W, 8: input beat width in bits, >=1.
- RATIO, 4: beats per output word, >=2.
- LSB_FIRST, 1: 1 = first beat goes to lane 0 (bits IN_W-1:0); 0 = first beat goes to lane RATIO-1 (top bits).

Ports:
- clk_in  input  1  clock, all logic rising-edge.
- rst_in  input  1  asynchronous, active-high reset.
- valid_data_in  input  1  input beat valid.
- data_in  input  IN_W  input beat.
- ready_out  output  1  packer accepts a beat this cycle.
- flush_in  input  1  single-cycle request to emit any partial word.
- valid_data_out  output  1  output word valid.
- data_out  output  IN_W*RATIO  packed word.
- keep_out  output  RATIO  per-lane valid mask, bit i = lane i.
- ready_in  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (async assert, sync-safe deassert): valid_data_out=0, data_out=0, keep_out=0. Lane count and accumulator cleared.
- Reset mid-word discards the partial word. No output is produced for it.
- Input handshake: a beat is accepted when valid_data_in && ready_out.
- Output handshake: a word transfers when valid_data_out && ready_in.
- ready_out = !valid_data_out || ready_in. This is combinational from registered state plus ready_in.
- Accepted beat k (k=0..RATIO-1) writes lane k if LSB_FIRST=1, else lane RATIO-1-k. The lane counter increments mod RATIO.
- Full word: when the beat with k=RATIO-1 is accepted in cycle N:
  - valid_data_out=1 in cycle N+1, with keep_out all ones.
  - The accumulator and counter clear, so beat 0 of the next word is acceptable in cycle N+1 if ready_out.
- Output hold: while valid_data_out && !ready_in, data_out and keep_out are held stable and ready_out=0.
- Back-to-back: RATIO-beat words stream at one beat per cycle with no bubbles while ready_in stays high.
- Flush, counter>0, no beat accepted in the same cycle: emit the partial word next cycle.
  - keep_out bits are set for the filled lanes only.
  - Unfilled lanes are driven 0.
  - Accumulator and counter clear.
- Flush in the same cycle as an accepted beat: the beat is packed first, then the result is emitted as a word (partial or full).
- Flush with counter=0 and no accepted beat: ignored, no output.
- Flush while ready_out=0: the request is registered as pending. It is honoured on the first cycle the output register frees. Only one pending flush is stored; later flushes before service coalesce into it.
- Lane order never affects keep_out semantics: keep bit i always describes data_out lane i. With LSB_FIRST=0, a 2-beat partial in RATIO=4 gives keep_out=4'b1100.
- No data is lost or duplicated under any ready_in pattern.

Test Plan:
- Default params, ready_in=1, send 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle later data_out=0x44332211, keep_out=4'hF, valid for 1 cycle.
- LSB_FIRST=0, same beats -> data_out=0x11223344, keep_out=4'hF.
- Send 0xAA,0xBB then pulse flush_in -> next cycle data_out=0x0000BBAA, keep_out=4'b0011. Then flush with empty accumulator -> no valid_data_out.
- 12 beats 0x01..0x0C back-to-back, ready_in low for 3 cycles after the first word -> ready_out=0 during the stall, first word 0x04030201 held stable. Words 0x08070605 and 0x0C0B0A09 follow in order, none lost.
- IN_W=4, RATIO=3, beats 0x1,0x2 plus flush on the same cycle as 0x3 -> data_out=12'h321, keep_out=3'b111.
- Assert rst_in asynchronously after 2 beats -> outputs 0 immediately. The following 4 beats 0x5,0x6,0x7,0x8 (IN_W=8) yield 0x08070605.
